dm_responder: RTL
=================

# dm_responder

Memory-side responder for the pipeline's M-stage data port. It accepts one load or store request at a time from the datapath and services it against an internal word-organised RAM after a fixed, parameterised latency. While the access is in flight it drives `stall` back to the hazard unit, so the M stage holds its request stable until the single-cycle response.

## Interface
- `ADDR_W`, default 10: word-address bits; RAM depth is 2^ADDR_W words, i.e. 4 KiB at the default.
- `LATENCY`, default 2: cycles from request acceptance to response. Legal range is 1..15.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-low. 0 sampled at a rising edge resets the block.
- `req_valid`  in  1: M stage presents an access. Held stable while `stall`=1.
- `req_write`  in  1: 1 = store, 0 = load.
- `req_addr`  in  32: byte address. Bits [1:0] are ignored for word selection.
- `req_wdata`  in  32: store data, already lane-aligned.
- `req_be`  in  4: byte enables for stores; bit i enables `wdata[8i+7:8i]`. Ignored on loads.
- `req_pc`  in  32: PC of the requesting instruction. Used only for the display feature.
- `req_ready`  out  1: 1 only in IDLE.
- `stall`  out  1: combinational, `req_valid & (state != RESP)`.
- `resp_valid`  out  1: one-cycle pulse when the access completes.
- `resp_rdata`  out  32: load data. Valid with `resp_valid`, 0 otherwise.
- `resp_err`  out  1: out-of-range address. Valid with `resp_valid`.

## Operation
- States and transitions:
  - IDLE → BUSY on `req_valid`. If LATENCY=1, IDLE → RESP directly.
  - BUSY → RESP when `cnt`=0.
  - RESP → IDLE unconditionally.
- Acceptance: in IDLE with `req_valid`=1, the block latches write, addr, wdata, be and pc, and loads `cnt` with LATENCY-2. With LATENCY=1 the counter is unused.
- BUSY: `cnt` decrements each cycle. The latched request is used throughout; the live `req_*` inputs are ignored after acceptance.
- Commit happens on the BUSY→RESP edge, or the IDLE→RESP edge when LATENCY=1:
  - Range check: the access is out of range if `addr[31:ADDR_W+2]` ≠ 0. In that case `err` is set, no write is performed and rdata is 0.
  - Store: byte lanes of `mem[addr[ADDR_W+1:2]]` are written per `be`. `be`=0000 is a legal no-op. rdata is 0.
  - Load: rdata is the full word at that index.
- RESP: `resp_valid`=1 and `stall`=0, so the pipeline advances this cycle. `req_ready`=0. A new request is accepted no earlier than the following IDLE cycle.
- `resp_rdata` and `resp_err` are registered, and are 0 outside RESP.

## Timing
- Request accepted at cycle t gives `resp_valid` at t+LATENCY. `stall` is high for cycles t..t+LATENCY-1 (when `req_valid` is held) and low at t+LATENCY.
- Back-to-back requests: next acceptance no earlier than t+LATENCY+1, giving a throughput of one access per LATENCY+1 cycles.
- Reset values: state = IDLE, `cnt` = 0, latched request = 0, all RAM words = 0. Outputs are `req_ready`=1, `stall`=`req_valid`, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0.
- Reset mid-operation (BUSY or RESP): the pending access is abandoned, no store is committed, and the block returns to IDLE.
- `req_valid` deasserting during BUSY, which is a protocol violation, is tolerated: the latched access completes normally.

## Configuration
- `DM_DISPLAY_EN` defined: every committed in-range store with `be`≠0 prints `@<pc>: *<byte addr word-aligned> <= <merged word>` in `$display` format `"@%h: *%h <= %h"`, at the commit edge.
- Not defined: no simulation output. Datapath behaviour is identical either way.

## Structure
- Package `dm_pkg` holds:
  - the state enum (IDLE, BUSY, RESP);
  - `DM_LAT_MAX` = 15;
  - the 4-bit counter width.
- Sub-module `dm_word_ram`: a 2^ADDR_W × 32 array with byte-enable write and combinational read port, plus synchronous active-low clear. `dm_responder` owns the FSM, counter, request latch and range check.

## Test plan
- Reset, LATENCY=2, load from 0x00000010: `resp_valid` at t+2, `resp_rdata`=0, `stall` high for 2 cycles.
- Store 0xDEADBEEF with be=1111 to 0x20, then load 0x20: rdata 0xDEADBEEF. With `DM_DISPLAY_EN`, exactly one line is printed: `*00000020 <= deadbeef`.
- Store 0x000000AA with be=0001 over 0x11223344 at 0x24, then load 0x24: rdata 0x112233AA.
- Load from 0x00010000 with ADDR_W=10: `resp_err`=1 and rdata 0. A store to the same address leaves the RAM unchanged.
- Store accepted, `reset`=0 one cycle later (LATENCY=3), then load the same address: rdata 0 and state IDLE after reset.
- LATENCY=1 back-to-back loads with `req_valid` held: `resp_valid` pulses every 2 cycles and `req_ready` is low in each RESP cycle.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared types and constants for the M-stage data-memory responder.
package dm_pkg;

    localparam int unsigned DM_LAT_MAX = 15;
    localparam int unsigned DM_CNT_W   = 4;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StResp
    } dm_state_e;

endpackage

// File: rtl/dm_word_ram.sv
// Word-organised RAM with per-byte write enables, combinational read and a synchronous
// active-low clear that zeroes every word.
module dm_word_ram #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              clr_ni,
    input  logic              we_i,
    input  logic [3:0]        be_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    logic [31:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (!clr_ni) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dm_responder.sv
// M-stage data-memory responder: one access in flight, fixed LATENCY, stall while busy.
// Define DM_DISPLAY_EN to print every committed in-range store with a nonzero byte mask.
module dm_responder
    import dm_pkg::*;
#(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        req_valid_i,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_be_i,
    input  logic [31:0] req_pc_i,
    output logic        req_ready_o,
    output logic        stall_o,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o
);

    if (LATENCY < 1 || LATENCY > DM_LAT_MAX) begin : g_bad_latency
        $error("dm_responder: LATENCY out of range 1..15");
    end

    localparam logic [DM_CNT_W-1:0] CntInit =
        (LATENCY >= 2) ? DM_CNT_W'(LATENCY - 2) : '0;

    dm_state_e           state_q, state_d;
    logic [DM_CNT_W-1:0] cnt_q, cnt_d;
    logic                write_q;
    logic [31:0]         addr_q, wdata_q, pc_q;
    logic [3:0]          be_q;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;

    logic                accept, commit, out_of_range;
    logic                c_write;
    logic [31:0]         c_addr, c_wdata, c_pc;
    logic [3:0]          c_be;
    logic [31:0]         ram_rdata;

    // With LATENCY=1 commit happens on the acceptance edge, so the live request is used.
    always_comb begin
        if (LATENCY == 1 && state_q == StIdle) begin
            c_write = req_write_i;
            c_addr  = req_addr_i;
            c_wdata = req_wdata_i;
            c_be    = req_be_i;
            c_pc    = req_pc_i;
        end else begin
            c_write = write_q;
            c_addr  = addr_q;
            c_wdata = wdata_q;
            c_be    = be_q;
            c_pc    = pc_q;
        end
    end

    assign out_of_range = |(c_addr >> (ADDR_W + 2));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    accept  = 1'b1;
                    cnt_d   = CntInit;
                    commit  = (LATENCY == 1);
                    state_d = (LATENCY == 1) ? StResp : StBusy;
                end
            end
            StBusy: begin
                if (cnt_q == '0) begin
                    commit  = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rdata_d = '0;
        err_d   = 1'b0;
        if (commit) begin
            err_d = out_of_range;
            if (!c_write && !out_of_range) begin
                rdata_d = ram_rdata;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            pc_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                write_q <= req_write_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                be_q    <= req_be_i;
                pc_q    <= req_pc_i;
            end
        end
    end

    dm_word_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (clk_i),
        .clr_ni  (reset_ni),
        .we_i    (commit && c_write && !out_of_range),
        .be_i    (c_be),
        .addr_i  (c_addr[ADDR_W+1:2]),
        .wdata_i (c_wdata),
        .rdata_o (ram_rdata)
    );

`ifdef DM_DISPLAY_EN
    logic [31:0] merged;

    always_comb begin
        merged = ram_rdata;
        for (int unsigned b = 0; b < 4; b++) begin
            if (c_be[b]) begin
                merged[8*b +: 8] = c_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_ni && commit && c_write && !out_of_range && c_be != 4'b0000) begin
            $display("@%h: *%h <= %h", c_pc, {c_addr[31:2], 2'b00}, merged);
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^c_pc;
`endif

    assign req_ready_o  = (state_q == StIdle);
    assign stall_o      = req_valid_i && (state_q != StResp);
    assign resp_valid_o = (state_q == StResp);
    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;

endmodule
